// File: rtl/sample_stream_packer.sv
// -----------------------------------------------------------------------------
// sample_stream_packer
//
// Packs a stream of capture samples into wide DRAM write words and presents
// them, with an incrementing word address, to a memory interface that
// accepts one word per cycle when write_allowed is high.
//
// Two storage stages:
//   * assembly register: lanes are filled in order, first sample in lane 0
//   * output register:   holds the word being offered (valid bit = write_req)
// A completed word moves to the output register in the same edge if the
// output is free or is being accepted that cycle. Otherwise the assembly
// register stalls, and samples arriving while stalled are dropped and
// flagged in the sticky overflow output.
// After PAGE_WORDS words have been accepted, pageFull rises. From then on
// write_req is held low and samples and flushes are ignored until reset.
//
// Build option:
//   PACKER_RLE_EN  when defined, each lane is 2*SAMPLE_W bits wide and holds
//                  {run count, sample value}. Repeated samples extend the
//                  pending run. A run is committed to a lane on a value
//                  change, when the count saturates at 2^SAMPLE_W-1, or on
//                  flush. When undefined, samples are packed raw, one per
//                  lane.
//
// Ports:
//   clk            system clock (single domain)
//   reset          synchronous, active-high reset
//   we             sample_data valid this cycle
//   sample_data    capture sample, SAMPLE_W bits
//   flush          one-cycle pulse: emit the partial word, zero-padded
//   write_allowed  memory interface accepts write_req this cycle
//   write_req      dram_data / dram_adx valid
//   dram_data      packed word, DATA_W bits
//   dram_adx       word address, ADX_W bits
//   pageFull       PAGE_WORDS words have been accepted
//   overflow       sticky: a sample was dropped
//   words_written  count of accepted words
// -----------------------------------------------------------------------------
module sample_stream_packer #(
  parameter int SAMPLE_W   = 16,
  parameter int DATA_W     = 128,
  parameter int ADX_W      = 27,
  parameter int ADX_STEP   = 8,
  parameter int BASE_ADX   = 0,
  parameter int PAGE_WORDS = 4096
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [SAMPLE_W-1:0] sample_data,
  input  logic                flush,
  input  logic                write_allowed,
  output logic                write_req,
  output logic [DATA_W-1:0]   dram_data,
  output logic [ADX_W-1:0]    dram_adx,
  output logic                pageFull,
  output logic                overflow,
  output logic [ADX_W-1:0]    words_written
);

`ifdef PACKER_RLE_EN
  localparam int LANE_W = 2 * SAMPLE_W;
`else
  localparam int LANE_W = SAMPLE_W;
`endif
  localparam int LANES = DATA_W / LANE_W;
  localparam int CNT_W = $clog2(LANES + 1);

  localparam logic [CNT_W-1:0] LANES_C   = CNT_W'(LANES);
  localparam logic [ADX_W-1:0] STEP_C    = ADX_W'(ADX_STEP);
  localparam logic [ADX_W-1:0] BASE_C    = ADX_W'(BASE_ADX);
  localparam logic [ADX_W-1:0] PAGE_C    = ADX_W'(PAGE_WORDS);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FILLING,
    ST_STALLED
  } state_e;

  state_e             state_q,     state_d;
  logic [CNT_W-1:0]   lane_cnt_q,  lane_cnt_d;
  logic [DATA_W-1:0]  asm_q,       asm_d;
  logic [DATA_W-1:0]  out_q,       out_d;
  logic               out_valid_q, out_valid_d;
  logic [ADX_W-1:0]   adx_q,       adx_d;
  logic [ADX_W-1:0]   words_q,     words_d;
  logic               page_full_q, page_full_d;
  logic               overflow_q,  overflow_d;

`ifdef PACKER_RLE_EN
  localparam logic [SAMPLE_W-1:0] RUN_MAX = {SAMPLE_W{1'b1}};

  logic [SAMPLE_W-1:0] run_val_q, run_val_d;
  logic [SAMPLE_W-1:0] run_cnt_q, run_cnt_d;   // 0 means no run pending
  logic [SAMPLE_W-1:0] rv_c;
  logic [SAMPLE_W-1:0] rc_c;
`endif

  // Working copies of the assembly word while this cycle's sample and
  // flush are applied in order.
  logic [DATA_W-1:0]  word_c;
  logic [CNT_W-1:0]   cnt_c;
  logic               complete_c;

  logic               accept;
  logic               out_free;

  // Once the page is full, the offered word is withdrawn, so it can never
  // be accepted.
  assign accept   = out_valid_q && write_allowed && !page_full_q;
  assign out_free = !out_valid_q || accept;

  // Writes one lane entry at lane index idx.
  function automatic logic [DATA_W-1:0] put_lane(
    input logic [DATA_W-1:0] w,
    input logic [CNT_W-1:0]  idx,
    input logic [LANE_W-1:0] e
  );
    logic [DATA_W-1:0] r;
    r = w;
    for (int i = 0; i < LANES; i++) begin
      if (CNT_W'(i) == idx) begin
        r[i*LANE_W +: LANE_W] = e;
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      lane_cnt_q  <= '0;
      asm_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      adx_q       <= BASE_C;
      words_q     <= '0;
      page_full_q <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef PACKER_RLE_EN
      run_val_q   <= '0;
      run_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      lane_cnt_q  <= lane_cnt_d;
      asm_q       <= asm_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      adx_q       <= adx_d;
      words_q     <= words_d;
      page_full_q <= page_full_d;
      overflow_q  <= overflow_d;
`ifdef PACKER_RLE_EN
      run_val_q   <= run_val_d;
      run_cnt_q   <= run_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    lane_cnt_d  = lane_cnt_q;
    asm_d       = asm_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    adx_d       = adx_q;
    words_d     = words_q;
    overflow_d  = overflow_q;
    word_c      = asm_q;
    cnt_c       = lane_cnt_q;
    complete_c  = 1'b0;
`ifdef PACKER_RLE_EN
    run_val_d   = run_val_q;
    run_cnt_d   = run_cnt_q;
    rv_c        = run_val_q;
    rc_c        = run_cnt_q;
`endif

    if (accept) begin
      out_valid_d = 1'b0;
      adx_d       = adx_q + STEP_C;
      words_d     = words_q + 1'b1;
    end

    if (state_q == ST_STALLED) begin
      // The assembly word is complete and waiting. New samples have nowhere
      // to go.
      if (we && !page_full_q) begin
        overflow_d = 1'b1;
      end
      if (out_free) begin
        out_d       = asm_q;
        out_valid_d = 1'b1;
        asm_d       = '0;
        lane_cnt_d  = '0;
        state_d     = ST_EMPTY;
      end
    end else begin
`ifdef PACKER_RLE_EN
      if (we && !page_full_q) begin
        if (rc_c == '0) begin
          rv_c = sample_data;
          rc_c = SAMPLE_W'(1);
        end else if (sample_data == rv_c) begin
          if (rc_c + 1'b1 == RUN_MAX) begin
            word_c = put_lane(word_c, cnt_c, {RUN_MAX, rv_c});
            cnt_c  = cnt_c + 1'b1;
            rc_c   = '0;
          end else begin
            rc_c = rc_c + 1'b1;
          end
        end else begin
          word_c = put_lane(word_c, cnt_c, {rc_c, rv_c});
          cnt_c  = cnt_c + 1'b1;
          rv_c   = sample_data;
          rc_c   = SAMPLE_W'(1);
        end
      end
      // Flush commits the pending run before padding. If a value change has
      // just filled the last lane, that run stays pending for the next word.
      if (flush && !page_full_q && rc_c != '0 && cnt_c != LANES_C) begin
        word_c = put_lane(word_c, cnt_c, {rc_c, rv_c});
        cnt_c  = cnt_c + 1'b1;
        rc_c   = '0;
      end
      run_val_d = rv_c;
      run_cnt_d = rc_c;
`else
      if (we && !page_full_q) begin
        word_c = put_lane(word_c, cnt_c, sample_data);
        cnt_c  = cnt_c + 1'b1;
      end
`endif
      // Unused lanes are already zero because the assembly register is
      // cleared whenever a word leaves it.
      if (cnt_c == LANES_C || (flush && !page_full_q && cnt_c != '0)) begin
        complete_c = 1'b1;
      end

      if (complete_c) begin
        if (out_free) begin
          out_d       = word_c;
          out_valid_d = 1'b1;
          asm_d       = '0;
          lane_cnt_d  = '0;
          state_d     = ST_EMPTY;
        end else begin
          // A flushed partial word also counts as full while it waits.
          asm_d      = word_c;
          lane_cnt_d = LANES_C;
          state_d    = ST_STALLED;
        end
      end else begin
        asm_d      = word_c;
        lane_cnt_d = cnt_c;
        state_d    = (cnt_c == '0) ? ST_EMPTY : ST_FILLING;
      end
    end

    page_full_d = page_full_q | (words_d == PAGE_C);
  end

  assign write_req     = out_valid_q && !page_full_q;
  assign dram_data     = out_q;
  assign dram_adx      = adx_q;
  assign pageFull      = page_full_q;
  assign overflow      = overflow_q;
  assign words_written = words_q;

endmodule

// File: tb/tb_sample_stream_packer.sv
// -----------------------------------------------------------------------------
// tb_sample_stream_packer
//
// Testbench for sample_stream_packer with default parameters (raw packing).
// A second instance with PAGE_WORDS=4 covers the page-full behaviour.
// The reference model keeps the partially assembled word as a queue of
// samples, plus a held word and an output slot.
// -----------------------------------------------------------------------------
module tb_sample_stream_packer;

  localparam int SW    = 16;
  localparam int DW    = 128;
  localparam int AW    = 27;
  localparam int LANES = DW / SW;
  localparam int PAGE_MAIN = 4096;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          we = 1'b0;
  logic [SW-1:0] sample_data = '0;
  logic          flush = 1'b0;
  logic          write_allowed = 1'b0;
  logic          write_req;
  logic [DW-1:0] dram_data;
  logic [AW-1:0] dram_adx;
  logic          pageFull;
  logic          overflow;
  logic [AW-1:0] words_written;

  logic          p_we = 1'b0;
  logic [SW-1:0] p_sample = '0;
  logic          p_flush = 1'b0;
  logic          p_wa = 1'b0;
  logic          p_write_req;
  logic [DW-1:0] p_dram_data;
  logic [AW-1:0] p_dram_adx;
  logic          p_pageFull;
  logic          p_overflow;
  logic [AW-1:0] p_words;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sample_stream_packer u_dut (
    .clk(clk), .reset(reset), .we(we), .sample_data(sample_data),
    .flush(flush), .write_allowed(write_allowed), .write_req(write_req),
    .dram_data(dram_data), .dram_adx(dram_adx), .pageFull(pageFull),
    .overflow(overflow), .words_written(words_written)
  );

  sample_stream_packer #(.PAGE_WORDS(4)) u_page (
    .clk(clk), .reset(reset), .we(p_we), .sample_data(p_sample),
    .flush(p_flush), .write_allowed(p_wa), .write_req(p_write_req),
    .dram_data(p_dram_data), .dram_adx(p_dram_adx), .pageFull(p_pageFull),
    .overflow(p_overflow), .words_written(p_words)
  );

  // ---------------- reference model ----------------
  logic [SW-1:0] m_pend[$];
  bit            m_held;
  logic [DW-1:0] m_held_word;
  bit            m_out_valid;
  logic [DW-1:0] m_out_word;
  logic [AW-1:0] m_adx;
  logic [AW-1:0] m_words;
  bit            m_pf;
  bit            m_ovf;

  task automatic model_reset();
    m_pend.delete();
    m_held      = 0;
    m_held_word = '0;
    m_out_valid = 0;
    m_out_word  = '0;
    m_adx       = '0;
    m_words     = '0;
    m_pf        = 0;
    m_ovf       = 0;
  endtask

  // Advances the model by one clock edge with the given inputs.
  task automatic model_step(input bit w, input logic [SW-1:0] s, input bit fl, input bit wa);
    bit acc, free, pf0;
    logic [DW-1:0] wd;
    pf0  = m_pf;
    acc  = m_out_valid && !pf0 && wa;
    free = !m_out_valid || acc;
    if (acc) begin
      $display("xfer adx=%0h data=%h", m_adx, m_out_word);
      m_out_valid = 0;
      m_adx       = m_adx + AW'(8);
      m_words     = m_words + 1'b1;
    end
    if (m_held) begin
      if (w && !pf0) m_ovf = 1;
      if (free) begin
        m_out_word  = m_held_word;
        m_out_valid = 1;
        m_held      = 0;
      end
    end else begin
      if (w && !pf0) m_pend.push_back(s);
      if (m_pend.size() == LANES || (fl && !pf0 && m_pend.size() > 0)) begin
        wd = '0;
        foreach (m_pend[i]) wd[i*SW +: SW] = m_pend[i];
        m_pend.delete();
        if (free) begin
          m_out_word  = wd;
          m_out_valid = 1;
        end else begin
          m_held_word = wd;
          m_held      = 1;
        end
      end
    end
    if (m_words == AW'(PAGE_MAIN)) m_pf = 1;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    we = 0; flush = 0; write_allowed = 0;
    p_we = 0; p_flush = 0; p_wa = 0;
    reset = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();
  endtask

  task automatic step(input bit w, input logic [SW-1:0] s, input bit fl, input bit wa);
    we = w; sample_data = s; flush = fl; write_allowed = wa;
    model_step(w, s, fl, wa);
    @(posedge clk);
    #1;
    we = 0; flush = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (write_req !== 1'b0) begin errors++; $display("FAIL reset_write_req got=%b want=0", write_req); end
    checks++; if (dram_data !== '0) begin errors++; $display("FAIL reset_dram_data got=%h want=0", dram_data); end
    checks++; if (dram_adx !== '0) begin errors++; $display("FAIL reset_dram_adx got=%h want=0", dram_adx); end
    checks++; if (pageFull !== 1'b0) begin errors++; $display("FAIL reset_pageFull got=%b want=0", pageFull); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b want=0", overflow); end
    checks++; if (words_written !== '0) begin errors++; $display("FAIL reset_words got=%0d want=0", words_written); end
    checks++; if (p_write_req !== 1'b0) begin errors++; $display("FAIL reset_page_write_req got=%b want=0", p_write_req); end
  endtask

  task automatic test_basic();
    logic [DW-1:0] exp;
    do_reset();
    for (int i = 1; i <= 8; i++) step(1, SW'(i), 0, 1);
    exp = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
    checks++; if (write_req !== 1'b1) begin errors++; $display("FAIL basic_write_req got=%b want=1", write_req); end
    checks++; if (dram_data !== exp) begin errors++; $display("FAIL basic_data got=%h want=%h", dram_data, exp); end
    checks++; if (dram_adx !== '0) begin errors++; $display("FAIL basic_adx got=%h want=0", dram_adx); end
    step(0, '0, 0, 1);
    checks++; if (write_req !== 1'b0) begin errors++; $display("FAIL basic_drop got=%b want=0", write_req); end
    checks++; if (words_written !== AW'(1)) begin errors++; $display("FAIL basic_words got=%0d want=1", words_written); end
    checks++; if (dram_adx !== AW'(8)) begin errors++; $display("FAIL basic_adx_next got=%h want=8", dram_adx); end
  endtask

  task automatic test_stall();
    logic [DW-1:0] w1, w2;
    do_reset();
    w1 = '0; w2 = '0;
    for (int k = 0; k < 8; k++) begin
      w1[k*SW +: SW] = SW'(k + 1);
      w2[k*SW +: SW] = SW'(k + 9);
    end
    for (int i = 1; i <= 16; i++) step(1, SW'(i), 0, 0);
    checks++; if (write_req !== 1'b1) begin errors++; $display("FAIL stall_write_req got=%b want=1", write_req); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL stall_no_ovf got=%b want=0", overflow); end
    step(1, SW'(17), 0, 0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL stall_ovf got=%b want=1", overflow); end
    checks++; if (dram_data !== w1 || dram_adx !== '0) begin errors++; $display("FAIL stall_word1 got=%h@%h want=%h@0", dram_data, dram_adx, w1); end
    step(0, '0, 0, 1);
    checks++; if (write_req !== 1'b1) begin errors++; $display("FAIL stall_b2b got=%b want=1", write_req); end
    checks++; if (dram_data !== w2 || dram_adx !== AW'(8)) begin errors++; $display("FAIL stall_word2 got=%h@%h want=%h@8", dram_data, dram_adx, w2); end
    step(0, '0, 0, 1);
    checks++; if (write_req !== 1'b0 || words_written !== AW'(2)) begin errors++; $display("FAIL stall_done got=%b/%0d want=0/2", write_req, words_written); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL stall_sticky got=%b want=1", overflow); end
  endtask

  task automatic test_flush();
    do_reset();
    step(1, SW'('hA1), 0, 1);
    step(1, SW'('hA2), 0, 1);
    step(1, SW'('hA3), 0, 1);
    step(0, '0, 1, 1);
    checks++; if (write_req !== 1'b1) begin errors++; $display("FAIL flush_write_req got=%b want=1", write_req); end
    checks++; if (dram_data !== 128'h00A3_00A2_00A1) begin errors++; $display("FAIL flush_data got=%h want=00a300a200a1", dram_data); end
    step(1, SW'('hB1), 0, 1);
    step(1, SW'('hB2), 1, 1);
    checks++; if (write_req !== 1'b1 || dram_data !== 128'h00B2_00B1) begin errors++; $display("FAIL flush_same_cycle got=%b/%h want=1/00b200b1", write_req, dram_data); end
    checks++; if (dram_adx !== AW'(8)) begin errors++; $display("FAIL flush_adx got=%h want=8", dram_adx); end
    step(0, '0, 1, 1);
    step(0, '0, 1, 1);
    checks++; if (write_req !== 1'b0 || words_written !== AW'(2)) begin errors++; $display("FAIL flush_empty got=%b/%0d want=0/2", write_req, words_written); end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] exp;
    do_reset();
    for (int i = 0; i < 5; i++) step(1, SW'($urandom), 0, 1);
    do_reset();
    checks++; if (write_req !== 1'b0) begin errors++; $display("FAIL midreset_req got=%b want=0", write_req); end
    step(0, '0, 0, 1);
    checks++; if (write_req !== 1'b0) begin errors++; $display("FAIL midreset_req_next got=%b want=0", write_req); end
    exp = '0;
    for (int i = 0; i < 8; i++) begin
      step(1, SW'(16 + i), 0, 1);
      exp[i*SW +: SW] = SW'(16 + i);
    end
    checks++; if (write_req !== 1'b1 || dram_data !== exp || dram_adx !== '0) begin errors++; $display("FAIL midreset_word got=%b/%h@%h want=1/%h@0", write_req, dram_data, dram_adx, exp); end
  endtask

  task automatic test_random();
    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      for (int c = 0; c < 400; c++) begin
        step($urandom_range(0, 9) < 7, SW'($urandom), $urandom_range(0, 19) == 0,
             $urandom_range(0, 3) <= blk);
        checks++; if (write_req !== (m_out_valid && !m_pf)) begin errors++; $display("FAIL rand_req c=%0d got=%b want=%b", c, write_req, m_out_valid && !m_pf); end
        checks++; if (dram_adx !== m_adx) begin errors++; $display("FAIL rand_adx c=%0d got=%h want=%h", c, dram_adx, m_adx); end
        checks++; if (words_written !== m_words) begin errors++; $display("FAIL rand_words c=%0d got=%0d want=%0d", c, words_written, m_words); end
        checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rand_ovf c=%0d got=%b want=%b", c, overflow, m_ovf); end
        checks++; if (pageFull !== m_pf) begin errors++; $display("FAIL rand_pf c=%0d got=%b want=%b", c, pageFull, m_pf); end
        if (m_out_valid) begin
          checks++; if (dram_data !== m_out_word) begin errors++; $display("FAIL rand_data c=%0d got=%h want=%h", c, dram_data, m_out_word); end
        end
      end
    end
  endtask

  task automatic test_page();
    int acc;
    do_reset();
    acc = 0;
    for (int c = 0; c < 60; c++) begin
      p_we = (c < 40);
      p_sample = SW'($urandom);
      p_wa = 1;
      if (p_write_req && p_wa) begin
        acc++;
        $display("page xfer adx=%0h data=%h", p_dram_adx, p_dram_data);
      end
      @(posedge clk);
      #1;
    end
    p_we = 0;
    checks++; if (acc != 4) begin errors++; $display("FAIL page_writes got=%0d want=4", acc); end
    checks++; if (p_pageFull !== 1'b1) begin errors++; $display("FAIL page_full got=%b want=1", p_pageFull); end
    checks++; if (p_words !== AW'(4)) begin errors++; $display("FAIL page_words got=%0d want=4", p_words); end
    checks++; if (p_overflow !== 1'b0) begin errors++; $display("FAIL page_ovf got=%b want=0", p_overflow); end
    checks++; if (p_write_req !== 1'b0) begin errors++; $display("FAIL page_req got=%b want=0", p_write_req); end
  endtask

`ifdef PACKER_RLE_EN
  task automatic test_rle();
    logic [DW-1:0] exp;
    do_reset();
    for (int i = 0; i < 5; i++) step(1, SW'('hAAAA), 0, 1);
    step(1, SW'('h5555), 0, 1);
    step(0, '0, 1, 1);
    exp = 128'h0001_5555_0005_AAAA;
    checks++; if (write_req !== 1'b1 || dram_data !== exp) begin errors++; $display("FAIL rle_word got=%b/%h want=1/%h", write_req, dram_data, exp); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef PACKER_RLE_EN
    test_rle();
`else
    test_basic();
    test_flush();
    test_stall();
    test_reset_mid();
    test_random();
`endif
    test_page();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sample_stream_packer.md
SAMPLE_STREAM_PACKER -- requirements
Module: sample_stream_packer

Interface
REQ-001 SAMPLE_W, 16, width of one capture sample in bits (8, 16 or 32).
REQ-002 DATA_W, 128, DRAM write word width; SHALL be a multiple of 2*SAMPLE_W.
REQ-003 ADX_W, 27, DRAM address width.
REQ-004 ADX_STEP, 8, address increment per accepted word (16-bit DRAM units).
REQ-005 BASE_ADX, 0, address of first word after reset.
REQ-006 PAGE_WORDS, 4096, words accepted before pageFull.
REQ-007 clk  in  1  system clock; one clock domain.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 we  in  1  sample_data valid this cycle.
REQ-010 sample_data  in  SAMPLE_W  capture sample.
REQ-011 flush  in  1  one-cycle pulse; emit partial word.
REQ-012 write_allowed  in  1  memory interface accepts write_req this cycle.
REQ-013 write_req  out  1  dram_data/dram_adx valid.
REQ-014 dram_data  out  DATA_W  packed word.
REQ-015 dram_adx  out  ADX_W  word address.
REQ-016 pageFull  out  1  PAGE_WORDS words accepted.
REQ-017 overflow  out  1  sticky; a sample was dropped.
REQ-018 words_written  out  ADX_W  count of accepted words.

Function
REQ-019 Two storage stages: assembly register (lane counter) and output register (valid bit = write_req).
REQ-020 LANES = DATA_W/SAMPLE_W (raw mode); lane i occupies dram_data[i*SAMPLE_W +: SAMPLE_W]; first sample in lane 0.
REQ-021 States: EMPTY (lane count 0), FILLING (1..LANES-1), STALLED (assembly full, output valid).
REQ-022 Final lane written -> word moves to output register next cycle if output free or being accepted same cycle; else STALLED.
REQ-023 Transfer occurs when write_req && write_allowed; write_req drops next cycle unless a new word loads that cycle (back-to-back words allowed, no bubble).
REQ-024 we while STALLED -> sample dropped, overflow set, held until reset.
REQ-025 Each accepted word: dram_adx advances by ADX_STEP (wraps modulo 2^ADX_W), words_written +1.
REQ-026 words_written == PAGE_WORDS -> pageFull=1; write_req forced 0, further samples ignored without setting overflow, until reset.
REQ-027 flush with lane count >0: unused lanes zero-filled, word moved to output per REQ-022; flush with count 0 has no effect.
REQ-028 we and flush same cycle: sample stored first, then flush applied to the resulting word.
REQ-029 Latency: last sample of a word at cycle N -> write_req high at N+1 when output free.

Reset
REQ-030 reset: write_req=0, dram_data=0, dram_adx=BASE_ADX, pageFull=0, overflow=0, words_written=0, lane count 0, state EMPTY.
REQ-031 reset mid-operation discards partial and pending words; no write_req in the cycle after reset.

Configuration
REQ-032 Macro PACKER_RLE_EN.
REQ-033 Defined: lane = 2*SAMPLE_W, {count, value}, count = consecutive occurrences; LANES = DATA_W/(2*SAMPLE_W).
REQ-034 Defined: repeated sample increments pending count; run committed to a lane on value change, count reaching 2^SAMPLE_W-1, or flush (pending run committed before padding).
REQ-035 Not defined: no run-length logic, raw packing per REQ-020.

Verification
REQ-036 Raw, defaults: 8 samples 0x0001..0x0008, write_allowed=1 -> one write_req, dram_data=0x0008_0007_0006_0005_0004_0003_0002_0001, dram_adx=0.
REQ-037 write_allowed=0, 17 continuous samples -> write_req held, STALLED after 16th, overflow=1 on 17th; release -> two words, adx 0 then 8.
REQ-038 3 samples 0xA1,0xA2,0xA3 then flush -> dram_data=0x...0000_00A3_00A2_00A1, upper lanes zero.
REQ-039 PAGE_WORDS=4, 40 samples -> exactly 4 writes, pageFull=1, words_written=4, overflow=0.
REQ-040 reset asserted with 5 samples assembled -> no write_req; next 8 samples produce word at adx 0.
REQ-041 PACKER_RLE_EN: 5x 0xAAAA, 1x 0x5555, flush -> lane0={0x0005,0xAAAA}, lane1={0x0001,0x5555}, lanes 2-3 zero.
